// File: rtl/log_pkg.sv
// Shared definitions for the log packet writer: status word layout, FSM encoding
// and default log-memory window.
package log_pkg;

    localparam int ST_FULL = 16;
    localparam int ST_TMO  = 17;
    localparam int ST_BUSY = 18;

    localparam logic [23:0] DEF_BASE_ADR = 24'h000000;
    localparam logic [23:0] DEF_END_ADR  = 24'hFFFFFF;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DATA = 2'd1,
        S_WRITE     = 2'd2,
        S_CLOSE     = 2'd3
    } state_t;

    function automatic logic [23:0] pack_status(
        input logic [15:0] cnt,
        input logic        full,
        input logic        tmo,
        input logic        busy
    );
        logic [23:0] s;
        s          = '0;
        s[15:0]    = cnt;
        s[ST_FULL] = full;
        s[ST_TMO]  = tmo;
        s[ST_BUSY] = busy;
        return s;
    endfunction

endpackage

// File: rtl/log_ack_timer.sv
// Loadable down-counter for memory-port masters: load on request issue, count
// while waiting, o_expired flags that the allowed wait has been used up.
module log_ack_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/log_pkt_writer.sv
// Writes the acquisition byte stream into byte-wide log memory over a req/ack
// port and publishes fixed-length packet boundaries plus a status word.
module log_pkt_writer
    import log_pkg::*;
#(
    parameter int          PKT_LEN     = 512,
    parameter logic [23:0] BASE_ADR    = DEF_BASE_ADR,
    parameter logic [23:0] END_ADR     = DEF_END_ADR,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        arm,
    input  logic        stop,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [23:0] mem_adr,
    output logic [7:0]  mem_dout,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic [23:0] start_adr,
    output logic [23:0] stop_adr,
    output logic [23:0] status,
    output logic        pkt_done
);

    localparam logic [15:0] PKT_LEN_W = 16'(PKT_LEN);
    localparam logic [15:0] TMO_LOAD  = 16'(ACK_TIMEOUT - 1);

    state_t      r_state;
    logic [23:0] r_wr_adr;
    logic [23:0] r_pkt_base;
    logic [23:0] r_last_adr;
    logic [23:0] r_mem_adr;
    logic [7:0]  r_mem_dout;
    logic        r_mem_we;
    logic [15:0] r_byte_cnt;
    logic        r_stop_seen;
    logic        r_full;
    logic        r_tmo;
    logic [23:0] r_start_adr;
    logic [23:0] r_stop_adr;
    logic [15:0] r_pkt_cnt;
    logic        r_pkt_done;

    logic        w_accept;
    logic        w_tmo_exp;
    logic [15:0] w_cnt_next;
    logic        w_ack_last;
    logic        w_close;
    logic [23:0] w_close_adr;

    assign w_accept   = (r_state == S_WAIT_DATA) && din_valid;
    assign w_cnt_next = r_byte_cnt + 16'd1;

    // The ack wait window opens when a byte is accepted and mem_we rises.
    log_ack_timer #(
        .CNT_W(16)
    ) u_ack_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_accept),
        .i_load_val (TMO_LOAD),
        .i_en       (r_state == S_WRITE),
        .o_expired  (w_tmo_exp)
    );

    // Packet close decision, shared by the FSM and the publish registers.
    always_comb begin
        w_ack_last  = (r_wr_adr == END_ADR) || (w_cnt_next == PKT_LEN_W) ||
                      r_stop_seen || stop;
        w_close     = 1'b0;
        w_close_adr = r_last_adr;
        case (r_state)
            S_WAIT_DATA: begin
                w_close = !din_valid && stop && (r_byte_cnt != 16'd0);
            end
            S_WRITE: begin
                if (mem_ack) begin
                    w_close     = w_ack_last;
                    w_close_adr = r_mem_adr;
                end else begin
                    w_close = w_tmo_exp && (r_byte_cnt != 16'd0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_wr_adr    <= BASE_ADR;
            r_pkt_base  <= BASE_ADR;
            r_last_adr  <= BASE_ADR;
            r_mem_adr   <= '0;
            r_mem_dout  <= '0;
            r_mem_we    <= 1'b0;
            r_byte_cnt  <= '0;
            r_stop_seen <= 1'b0;
            r_full      <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_wr_adr    <= BASE_ADR;
                        r_pkt_base  <= BASE_ADR;
                        r_byte_cnt  <= '0;
                        r_stop_seen <= 1'b0;
                        r_full      <= 1'b0;
                        r_tmo       <= 1'b0;
                        r_state     <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    if (din_valid) begin
                        r_mem_adr   <= r_wr_adr;
                        r_mem_dout  <= din;
                        r_mem_we    <= 1'b1;
                        r_stop_seen <= stop;
                        r_state     <= S_WRITE;
                    end else if (stop) begin
                        r_stop_seen <= 1'b1;
                        r_state     <= w_close ? S_CLOSE : S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (stop) begin
                        r_stop_seen <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_mem_we   <= 1'b0;
                        r_byte_cnt <= w_cnt_next;
                        r_last_adr <= r_mem_adr;
                        if (r_wr_adr == END_ADR) begin
                            r_full <= 1'b1;
                        end
                        if (w_ack_last) begin
                            r_state <= S_CLOSE;
                        end else begin
                            r_wr_adr <= r_wr_adr + 24'd1;
                            r_state  <= S_WAIT_DATA;
                        end
                    end else if (w_tmo_exp) begin
                        // Unacknowledged byte is dropped; only acked bytes form the packet.
                        r_mem_we <= 1'b0;
                        r_tmo    <= 1'b1;
                        r_state  <= w_close ? S_CLOSE : S_IDLE;
                    end
                end
                S_CLOSE: begin
                    if (r_full || r_tmo || r_stop_seen || stop) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_wr_adr    <= r_wr_adr + 24'd1;
                        r_pkt_base  <= r_wr_adr + 24'd1;
                        r_byte_cnt  <= '0;
                        r_stop_seen <= 1'b0;
                        r_state     <= S_WAIT_DATA;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Packet descriptors are loaded on entry to CLOSE so they are valid with pkt_done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_adr <= '0;
            r_stop_adr  <= '0;
            r_pkt_cnt   <= '0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_pkt_done <= w_close;
            if (w_close) begin
                r_start_adr <= r_pkt_base;
                r_stop_adr  <= w_close_adr;
                r_pkt_cnt   <= r_pkt_cnt + 16'd1;
            end else if ((r_state == S_IDLE) && arm) begin
                r_pkt_cnt <= '0;
            end
        end
    end

    assign din_ready = (r_state == S_WAIT_DATA);
    assign mem_adr   = r_mem_adr;
    assign mem_dout  = r_mem_dout;
    assign mem_we    = r_mem_we;
    assign start_adr = r_start_adr;
    assign stop_adr  = r_stop_adr;
    assign pkt_done  = r_pkt_done;
    assign status    = pack_status(r_pkt_cnt, r_full, r_tmo, r_state != S_IDLE);

endmodule

// File: tb/tb_log_pkt_writer.sv
// Directed bench for log_pkt_writer: instance 0 has an open address window,
// instance 1 has END_ADR five bytes past BASE_ADR.
module tb_log_pkt_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        arm [2];
    logic        stop [2];
    logic [7:0]  din [2];
    logic        din_valid [2];
    logic        din_ready [2];
    logic [23:0] mem_adr [2];
    logic [7:0]  mem_dout [2];
    logic        mem_we [2];
    logic        mem_ack [2];
    logic [23:0] start_adr [2];
    logic [23:0] stop_adr [2];
    logic [23:0] status [2];
    logic        pkt_done [2];

    bit          hold [2];
    bit          dly [2];
    int          n_wr [2];
    int          n_pkt [2];
    logic [23:0] log_adr [2][64];
    logic [7:0]  log_dat [2][64];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  din;
        logic [23:0] adr;
        int          npkt;
        logic [23:0] st;
        logic [23:0] sp;
        logic [23:0] status;
    } vec_t;

    vec_t tv [10];

    always #5 clk = ~clk;

    log_pkt_writer #(
        .PKT_LEN(4), .BASE_ADR(24'h000000), .END_ADR(24'hFFFFFF), .ACK_TIMEOUT(8)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .arm(arm[0]), .stop(stop[0]),
        .din(din[0]), .din_valid(din_valid[0]), .din_ready(din_ready[0]),
        .mem_adr(mem_adr[0]), .mem_dout(mem_dout[0]), .mem_we(mem_we[0]),
        .mem_ack(mem_ack[0]), .start_adr(start_adr[0]), .stop_adr(stop_adr[0]),
        .status(status[0]), .pkt_done(pkt_done[0])
    );

    log_pkt_writer #(
        .PKT_LEN(4), .BASE_ADR(24'h000000), .END_ADR(24'h000005), .ACK_TIMEOUT(8)
    ) u_dut1 (
        .clk(clk), .reset_n(reset_n), .arm(arm[1]), .stop(stop[1]),
        .din(din[1]), .din_valid(din_valid[1]), .din_ready(din_ready[1]),
        .mem_adr(mem_adr[1]), .mem_dout(mem_dout[1]), .mem_we(mem_we[1]),
        .mem_ack(mem_ack[1]), .start_adr(start_adr[1]), .stop_adr(stop_adr[1]),
        .status(status[1]), .pkt_done(pkt_done[1])
    );

    // Memory model: ack one cycle after mem_we is first seen, log completed writes,
    // count pkt_done pulses.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (pkt_done[k] === 1'b1) n_pkt[k]++;
            if (mem_we[k] === 1'b1 && mem_ack[k] !== 1'b1 && !hold[k]) begin
                if (dly[k]) begin
                    mem_ack[k] = 1'b1;
                    dly[k] = 1'b0;
                    if (n_wr[k] < 64) begin
                        log_adr[k][n_wr[k]] = mem_adr[k];
                        log_dat[k][n_wr[k]] = mem_dout[k];
                    end
                    n_wr[k]++;
                end else begin
                    dly[k] = 1'b1;
                end
            end else begin
                mem_ack[k] = 1'b0;
                dly[k] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_arm(input int k);
        arm[k] = 1'b1;
        tick(1);
        arm[k] = 1'b0;
    endtask

    task automatic pulse_stop(input int k);
        stop[k] = 1'b1;
        tick(1);
        stop[k] = 1'b0;
    endtask

    task automatic send_byte(input int k, input logic [7:0] d, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (din_ready[k] === 1'b1) break;
            tick(1);
        end
        if (din_ready[k] !== 1'b1) return;
        din[k] = d;
        din_valid[k] = 1'b1;
        tick(1);
        din_valid[k] = 1'b0;
        ok = 1'b1;
    endtask

    task automatic chk_reset_outputs(input int k, input string tag);
        chk({tag, "_mem_we"}, {31'd0, mem_we[k]}, 32'd0);
        chk({tag, "_din_ready"}, {31'd0, din_ready[k]}, 32'd0);
        chk({tag, "_pkt_done"}, {31'd0, pkt_done[k]}, 32'd0);
        chk({tag, "_status"}, {8'd0, status[k]}, 32'd0);
        chk({tag, "_start_adr"}, {8'd0, start_adr[k]}, 32'd0);
        chk({tag, "_stop_adr"}, {8'd0, stop_adr[k]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int wbase;
        int pbase;
        int n;

        tv[0] = '{8'h11, 24'd0, 0, 24'd0, 24'd0, 24'h040000};
        tv[1] = '{8'h22, 24'd1, 0, 24'd0, 24'd0, 24'h040000};
        tv[2] = '{8'h33, 24'd2, 0, 24'd0, 24'd0, 24'h040000};
        tv[3] = '{8'h44, 24'd3, 1, 24'd0, 24'd3, 24'h040001};
        tv[4] = '{8'h55, 24'd4, 1, 24'd0, 24'd3, 24'h040001};
        tv[5] = '{8'h66, 24'd5, 1, 24'd0, 24'd3, 24'h040001};
        tv[6] = '{8'h77, 24'd6, 1, 24'd0, 24'd3, 24'h040001};
        tv[7] = '{8'h88, 24'd7, 2, 24'd4, 24'd7, 24'h040002};
        tv[8] = '{8'h99, 24'd8, 2, 24'd4, 24'd7, 24'h040002};
        tv[9] = '{8'hAA, 24'd9, 2, 24'd4, 24'd7, 24'h040002};

        for (int k = 0; k < 2; k++) begin
            arm[k] = 1'b0; stop[k] = 1'b0; din[k] = 8'h00; din_valid[k] = 1'b0;
            hold[k] = 1'b0;
        end
        reset_n = 1'b0;
        tick(3);
        chk_reset_outputs(0, "rst0");
        chk("rst1_status", {8'd0, status[1]}, 32'd0);
        chk("rst1_din_ready", {31'd0, din_ready[1]}, 32'd0);
        reset_n = 1'b1;
        tick(2);
        chk("idle_din_ready", {31'd0, din_ready[0]}, 32'd0);

        // Streaming 10 bytes into 4-byte packets, then stop closes the remainder.
        pulse_arm(0);
        wbase = n_wr[0];
        for (int i = 0; i < 10; i++) begin
            send_byte(0, tv[i].din, ok);
            tick(4);
            chk($sformatf("v%0d_accept", i), {31'd0, ok}, 32'd1);
            chk($sformatf("v%0d_wadr", i), {8'd0, log_adr[0][wbase + i]}, {8'd0, tv[i].adr});
            chk($sformatf("v%0d_wdat", i), {24'd0, log_dat[0][wbase + i]}, {24'd0, tv[i].din});
            chk($sformatf("v%0d_npkt", i), n_pkt[0], tv[i].npkt);
            chk($sformatf("v%0d_start", i), {8'd0, start_adr[0]}, {8'd0, tv[i].st});
            chk($sformatf("v%0d_stop", i), {8'd0, stop_adr[0]}, {8'd0, tv[i].sp});
            chk($sformatf("v%0d_status", i), {8'd0, status[0]}, {8'd0, tv[i].status});
        end
        pulse_stop(0);
        tick(3);
        chk("stop_npkt", n_pkt[0], 3);
        chk("stop_start", {8'd0, start_adr[0]}, 32'd8);
        chk("stop_stop", {8'd0, stop_adr[0]}, 32'd9);
        chk("stop_status", {8'd0, status[0]}, 32'h000003);
        chk("stop_din_ready", {31'd0, din_ready[0]}, 32'd0);

        // Address window end reached mid-packet on instance 1.
        pulse_arm(1);
        wbase = n_wr[1];
        for (int i = 0; i < 6; i++) begin
            send_byte(1, 8'(8'hA0 + i), ok);
            tick(4);
            chk($sformatf("full_accept%0d", i), {31'd0, ok}, 32'd1);
            if (i == 3) begin
                chk("full_pkt1_start", {8'd0, start_adr[1]}, 32'd0);
                chk("full_pkt1_stop", {8'd0, stop_adr[1]}, 32'd3);
            end
        end
        chk("full_last_wadr", {8'd0, log_adr[1][wbase + 5]}, 32'd5);
        chk("full_npkt", n_pkt[1], 2);
        chk("full_start", {8'd0, start_adr[1]}, 32'd4);
        chk("full_stop", {8'd0, stop_adr[1]}, 32'd5);
        chk("full_status", {8'd0, status[1]}, 32'h010002);
        for (int i = 6; i < 8; i++) begin
            send_byte(1, 8'(8'hA0 + i), ok);
            chk($sformatf("full_reject%0d", i), {31'd0, ok}, 32'd0);
        end
        chk("full_nwr", n_wr[1] - wbase, 6);

        // Ack withheld on the third byte: mem_we must drop after ACK_TIMEOUT cycles.
        pulse_arm(0);
        wbase = n_wr[0];
        pbase = n_pkt[0];
        send_byte(0, 8'hC1, ok); tick(4);
        send_byte(0, 8'hC2, ok); tick(4);
        hold[0] = 1'b1;
        send_byte(0, 8'hC3, ok);
        n = 0;
        while (mem_we[0] === 1'b1 && n < 50) begin
            n++;
            tick(1);
        end
        chk("tmo_we_cycles", n, 8);
        hold[0] = 1'b0;
        tick(3);
        chk("tmo_npkt", n_pkt[0] - pbase, 1);
        chk("tmo_nwr", n_wr[0] - wbase, 2);
        chk("tmo_start", {8'd0, start_adr[0]}, 32'd0);
        chk("tmo_stop", {8'd0, stop_adr[0]}, 32'd1);
        chk("tmo_status", {8'd0, status[0]}, 32'h020001);

        // Asynchronous reset while a write is outstanding.
        pulse_arm(0);
        hold[0] = 1'b1;
        send_byte(0, 8'hD1, ok);
        tick(2);
        chk("rstw_pre_we", {31'd0, mem_we[0]}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs(0, "rstw");
        hold[0] = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        pulse_arm(0);
        wbase = n_wr[0];
        send_byte(0, 8'h5A, ok);
        tick(4);
        chk("rstw_rearm_wadr", {8'd0, log_adr[0][wbase]}, 32'd0);
        chk("rstw_rearm_wdat", {24'd0, log_dat[0][wbase]}, 32'h5A);

        // Close that one-byte packet, then stop with nothing written, then ignored arm.
        pbase = n_pkt[0];
        pulse_stop(0);
        tick(3);
        chk("one_npkt", n_pkt[0] - pbase, 1);
        chk("one_stop", {8'd0, stop_adr[0]}, 32'd0);
        chk("one_status", {8'd0, status[0]}, 32'h000001);

        pulse_arm(0);
        pbase = n_pkt[0];
        pulse_stop(0);
        tick(3);
        chk("empty_npkt", n_pkt[0] - pbase, 0);
        chk("empty_status", {8'd0, status[0]}, 32'h000000);

        pulse_arm(0);
        wbase = n_wr[0];
        send_byte(0, 8'h61, ok); tick(4);
        pulse_arm(0);
        tick(1);
        chk("busyarm_ready", {31'd0, din_ready[0]}, 32'd1);
        send_byte(0, 8'h62, ok); tick(4);
        chk("busyarm_wadr0", {8'd0, log_adr[0][wbase]}, 32'd0);
        chk("busyarm_wadr1", {8'd0, log_adr[0][wbase + 1]}, 32'd1);
        chk("busyarm_status", {8'd0, status[0]}, 32'h040000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
